// File: rtl/dot_matrix_decoder_if.sv
// Bus bundle for the dot-matrix decoder: scan inputs, readback port and
// glyph/frame status outputs. The decoder attaches through the slave modport.
interface dot_matrix_decoder_if;
    logic [7:0] dot_row;
    logic [7:0] dot_col;
    logic [2:0] rd_row;
    logic [7:0] rd_col;
    logic [1:0] glyph;
    logic       glyph_valid;
    logic       unknown;
    logic       frame_strobe;
    logic       seq_err;
    logic [7:0] frame_count;

    modport master (
        output dot_row, dot_col, rd_row,
        input  rd_col, glyph, glyph_valid, unknown, frame_strobe, seq_err, frame_count
    );

    modport slave (
        input  dot_row, dot_col, rd_row,
        output rd_col, glyph, glyph_valid, unknown, frame_strobe, seq_err, frame_count
    );
endinterface

// File: rtl/dot_matrix_decoder.sv
// Dot-matrix decoder: snoops a row-scanned 8x8 LED driver, rebuilds each
// complete frame, keeps it in a shadow buffer for readback and matches it
// against four fixed glyphs.
module dot_matrix_decoder (
    input  logic                 clk,
    input  logic                 reset,
    dot_matrix_decoder_if.slave  bus
);

    localparam logic [0:0] ST_HUNT    = 1'b0;
    localparam logic [0:0] ST_CAPTURE = 1'b1;

    // Glyph bitmaps, row 0 in the most significant byte.
    localparam logic [63:0] GLYPH0 = 64'h0C0C_197E_9818_2848;
    localparam logic [63:0] GLYPH1 = 64'h0024_3CBD_FF3C_3C00;
    localparam logic [63:0] GLYPH2 = 64'h1818_3C3C_5A18_1824;
    localparam logic [63:0] GLYPH3 = 64'h1824_4281_4242_427E;

    logic [7:0]  r_row;
    logic [7:0]  r_col;
    logic [0:0]  r_state;
    logic [2:0]  r_last;
    logic [7:0]  r_work   [8];
    logic [7:0]  r_shadow [8];
    logic        r_done;
    logic        r_strobe;
    logic        r_seq_err;
    logic [7:0]  r_count;
    logic [1:0]  r_glyph;
    logic        r_valid;
    logic        r_unknown;
    logic [7:0]  r_rd_col;

    logic [7:0]  w_low;
    logic        w_idle;
    logic        w_valid;
    logic [2:0]  w_idx;
    logic        w_store;
    logic        w_clear;
    logic        w_complete;
    logic        w_error;
    logic [0:0]  w_next_state;
    logic [2:0]  w_next_last;
    logic [63:0] w_flat;
    logic        w_match;
    logic [1:0]  w_code;

    // Input stage: every decision downstream works on this registered copy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_row <= 8'hFF;
            r_col <= 8'h00;
        end else begin
            r_row <= bus.dot_row;
            r_col <= bus.dot_col;
        end
    end

    // Classify the sampled row select as idle, a single valid row, or illegal.
    always_comb begin
        w_low   = ~r_row;
        w_idle  = (r_row == 8'h00) || (r_row == 8'hFF);
        w_valid = $onehot(w_low);
        w_idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_low[i]) w_idx = 3'(7 - i);
        end
    end

    // Sequence tracker: decides whether the sampled row is stored, completes a frame or is an error.
    always_comb begin
        w_store      = 1'b0;
        w_clear      = 1'b0;
        w_complete   = 1'b0;
        w_error      = 1'b0;
        w_next_state = r_state;
        w_next_last  = r_last;
        case (r_state)
            ST_HUNT: begin
                if (w_valid && (w_idx == 3'd0)) begin
                    w_store      = 1'b1;
                    w_next_state = ST_CAPTURE;
                    w_next_last  = 3'd0;
                end
            end
            ST_CAPTURE: begin
                if (w_valid && (w_idx == r_last)) begin
                    w_store = 1'b1;
                end else if (w_valid && (w_idx == r_last + 3'd1)) begin
                    w_store     = 1'b1;
                    w_next_last = w_idx;
                    if (w_idx == 3'd7) begin
                        w_complete   = 1'b1;
                        w_next_state = ST_HUNT;
                    end
                end else if (!w_idle) begin
                    w_error      = 1'b1;
                    w_clear      = 1'b1;
                    w_next_state = ST_HUNT;
                    if (w_valid && (w_idx == 3'd0)) begin
                        w_store      = 1'b1;
                        w_next_state = ST_CAPTURE;
                        w_next_last  = 3'd0;
                    end
                end
            end
            default: w_next_state = ST_HUNT;
        endcase
    end

    // State register plus the one-cycle sequence error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_HUNT;
            r_last    <= 3'd0;
            r_seq_err <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_last    <= w_next_last;
            r_seq_err <= w_error;
        end
    end

    // Working frame: cleared on a sequence error, a restart row 0 lands on top of the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) r_work[i] <= 8'h00;
        end else begin
            if (w_clear) begin
                for (int i = 0; i < 8; i++) r_work[i] <= 8'h00;
            end
            if (w_store) r_work[w_idx] <= r_col;
        end
    end

    // Shadow frame: takes the whole working frame, with row 7 straight from the input stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) r_shadow[i] <= 8'h00;
        end else if (w_complete) begin
            for (int i = 0; i < 7; i++) r_shadow[i] <= r_work[i];
            r_shadow[7] <= r_col;
        end
    end

    // Flatten the shadow frame and look it up against the glyph table.
    always_comb begin
        w_flat  = {r_shadow[0], r_shadow[1], r_shadow[2], r_shadow[3],
                   r_shadow[4], r_shadow[5], r_shadow[6], r_shadow[7]};
        w_match = 1'b1;
        w_code  = 2'd0;
        if (w_flat == GLYPH0)      w_code = 2'd0;
        else if (w_flat == GLYPH1) w_code = 2'd1;
        else if (w_flat == GLYPH2) w_code = 2'd2;
        else if (w_flat == GLYPH3) w_code = 2'd3;
        else                       w_match = 1'b0;
    end

    // Frame result stage, one edge behind the shadow update.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done    <= 1'b0;
            r_strobe  <= 1'b0;
            r_count   <= 8'h00;
            r_glyph   <= 2'd0;
            r_valid   <= 1'b0;
            r_unknown <= 1'b0;
        end else begin
            r_done   <= w_complete;
            r_strobe <= r_done;
            if (r_done) begin
                r_count   <= r_count + 8'd1;
                r_valid   <= w_match;
                r_unknown <= !w_match;
                if (w_match) r_glyph <= w_code;
            end
        end
    end

    // Registered readback; a same-edge shadow update is not yet visible here.
    always_ff @(posedge clk) begin
        if (reset) r_rd_col <= 8'h00;
        else       r_rd_col <= r_shadow[bus.rd_row];
    end

    assign bus.rd_col       = r_rd_col;
    assign bus.glyph        = r_glyph;
    assign bus.glyph_valid  = r_valid;
    assign bus.unknown      = r_unknown;
    assign bus.frame_strobe = r_strobe;
    assign bus.seq_err      = r_seq_err;
    assign bus.frame_count  = r_count;

endmodule

// File: tb/tb_dot_matrix_decoder.sv
// Testbench for dot_matrix_decoder: directed scans, expected frame and error
// events queued at stimulus time and checked by an independent monitor.
module tb_dot_matrix_decoder;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int         kind;
        int         cycle;
        logic [1:0] glyph;
        logic       valid;
        logic       unknown;
        logic [7:0] count;
    } exp_t;

    typedef logic [7:0] frame_t [8];

    exp_t       expQ [$];
    exp_t       monE;
    logic [7:0] expCount = 8'h00;
    frame_t     g0, g1, g2, g3, bad;

    dot_matrix_decoder_if bus ();

    dot_matrix_decoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used to time-stamp expected events.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [7:0] rowSel(input int r);
        logic [7:0] top;
        top = 8'h80;
        return ~(top >> r);
    endfunction

    task automatic applyStimulus(input logic [7:0] row, input logic [7:0] col);
        @(negedge clk);
        bus.dot_row = row;
        bus.dot_col = col;
    endtask

    task automatic pushStrobe(input logic [1:0] g, input logic v, input logic u);
        exp_t e;
        expCount = expCount + 8'd1;
        e.kind = 1; e.cycle = cyc + 3; e.glyph = g; e.valid = v; e.unknown = u; e.count = expCount;
        expQ.push_back(e);
    endtask

    task automatic pushErr();
        exp_t e;
        e.kind = 2; e.cycle = cyc + 2; e.glyph = 2'd0; e.valid = 1'b0; e.unknown = 1'b0; e.count = 8'h00;
        expQ.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(8'hFF, 8'h00);
    endtask

    task automatic scanFrame(input frame_t f, input int hold, input bit gap,
                             input logic [1:0] g, input logic v, input logic u);
        for (int r = 0; r < 8; r++) begin
            for (int h = 0; h < hold; h++) begin
                applyStimulus(rowSel(r), f[r]);
                if (r == 7 && h == 0) pushStrobe(g, v, u);
            end
            if (gap) applyStimulus(8'h00, 8'h00);
        end
    endtask

    // Monitor: every strobe or error pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.frame_strobe && bus.seq_err) begin
            checks++;
            errors++;
            $display("[TB] FAIL overlap: strobe and seq_err both 1, required not both");
        end
        if (bus.frame_strobe || bus.seq_err) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_event: strobe=%0b seq_err=%0b at cycle %0d, required none",
                         bus.frame_strobe, bus.seq_err, cyc);
            end else begin
                monE = expQ.pop_front();
                checkOutput("event_kind", bus.frame_strobe ? 1 : 2, monE.kind);
                checkOutput("event_cycle", cyc, monE.cycle);
                if (monE.kind == 1) begin
                    checkOutput("glyph", int'(bus.glyph), int'(monE.glyph));
                    checkOutput("glyph_valid", int'(bus.glyph_valid), int'(monE.valid));
                    checkOutput("unknown", int'(bus.unknown), int'(monE.unknown));
                    checkOutput("frame_count", int'(bus.frame_count), int'(monE.count));
                end
            end
        end
    end

    // Directed scenario sequence.
    initial begin
        g0 = '{8'h0C, 8'h0C, 8'h19, 8'h7E, 8'h98, 8'h18, 8'h28, 8'h48};
        g1 = '{8'h00, 8'h24, 8'h3C, 8'hBD, 8'hFF, 8'h3C, 8'h3C, 8'h00};
        g2 = '{8'h18, 8'h18, 8'h3C, 8'h3C, 8'h5A, 8'h18, 8'h18, 8'h24};
        g3 = '{8'h18, 8'h24, 8'h42, 8'h81, 8'h42, 8'h42, 8'h42, 8'h7E};

        reset       = 1'b1;
        bus.dot_row = 8'hFF;
        bus.dot_col = 8'h00;
        bus.rd_row  = 3'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset_rd_col", int'(bus.rd_col), 0);
        checkOutput("reset_glyph", int'(bus.glyph), 0);
        checkOutput("reset_glyph_valid", int'(bus.glyph_valid), 0);
        checkOutput("reset_unknown", int'(bus.unknown), 0);
        checkOutput("reset_strobe", int'(bus.frame_strobe), 0);
        checkOutput("reset_seq_err", int'(bus.seq_err), 0);
        checkOutput("reset_count", int'(bus.frame_count), 0);
        reset = 1'b0;
        idle(2);

        // Three back-to-back frames of glyph 1.
        repeat (3) scanFrame(g1, 1, 1'b0, 2'd1, 1'b1, 1'b0);
        idle(4);
        checkOutput("g1_glyph", int'(bus.glyph), 1);
        checkOutput("g1_count", int'(bus.frame_count), 3);

        // Glyph 3 with a corrupted row 4 decodes as unknown.
        bad    = g3;
        bad[4] = 8'h43;
        scanFrame(bad, 1, 1'b0, 2'd1, 1'b0, 1'b1);
        idle(4);
        bus.rd_row = 3'd4;
        @(negedge clk);
        checkOutput("rd_col_row4", int'(bus.rd_col), 8'h43);
        bus.rd_row = 3'd7;
        @(negedge clk);
        checkOutput("rd_col_row7", int'(bus.rd_col), 8'h7E);
        checkOutput("unk_glyph_held", int'(bus.glyph), 1);
        checkOutput("unk_flag", int'(bus.unknown), 1);

        // Skipped row 3 raises one error, then a clean glyph 2 scan.
        applyStimulus(rowSel(0), g2[0]);
        applyStimulus(rowSel(1), g2[1]);
        applyStimulus(rowSel(2), g2[2]);
        applyStimulus(rowSel(4), g2[4]);
        pushErr();
        idle(3);
        scanFrame(g2, 1, 1'b0, 2'd2, 1'b1, 1'b0);
        idle(4);

        // Glyph 0 with each row held three cycles and idle gaps between rows.
        scanFrame(g0, 3, 1'b1, 2'd0, 1'b1, 1'b0);
        idle(4);

        // Two rows selected at once mid-frame, then run the counter round to zero.
        applyStimulus(rowSel(0), g3[0]);
        applyStimulus(rowSel(1), g3[1]);
        applyStimulus(rowSel(2), g3[2]);
        applyStimulus(8'b0011_1111, 8'hAA);
        pushErr();
        idle(3);
        for (int n = 0; n < 250; n++) scanFrame(g3, 1, 1'b0, 2'd3, 1'b1, 1'b0);
        idle(4);
        checkOutput("count_wrap", int'(bus.frame_count), 0);

        // Reset in the middle of a glyph 0 scan, then a clean glyph 0 scan.
        for (int r = 0; r < 5; r++) applyStimulus(rowSel(r), g0[r]);
        applyStimulus(rowSel(5), g0[5]);
        reset = 1'b1;
        idle(2);
        expCount = 8'h00;
        checkOutput("midreset_count", int'(bus.frame_count), 0);
        checkOutput("midreset_valid", int'(bus.glyph_valid), 0);
        reset = 1'b0;
        idle(2);
        scanFrame(g0, 1, 1'b0, 2'd0, 1'b1, 1'b0);
        idle(4);
        bus.rd_row = 3'd3;
        @(negedge clk);
        checkOutput("final_rd_col", int'(bus.rd_col), 8'h7E);
        checkOutput("final_count", int'(bus.frame_count), 1);
        checkOutput("final_glyph_valid", int'(bus.glyph_valid), 1);

        checkOutput("events_outstanding", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dot_matrix_decoder.md
DOT_MATRIX_DECODER -- requirements
Module: dot_matrix_decoder

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high; sampled on rising edge of clk.
REQ-003 SHALL have ports: dot_row  in  8  active-low row select from a row-scanned 8x8 driver; 8'b01111111 = row 0 ... 8'b11111110 = row 7.
REQ-004 SHALL have ports: dot_col  in  8  column pattern for the selected row, bit 7 = leftmost, 1 = lit.
REQ-005 SHALL have ports: rd_row  in  3  readback row index into the last completed frame.
REQ-006 SHALL have ports: rd_col  out  8  registered readback data for rd_row.
REQ-007 SHALL have ports: glyph  out  2  code of the last recognised glyph.
REQ-008 SHALL have ports: glyph_valid  out  1  high when the last completed frame matched a glyph.
REQ-009 SHALL have ports: unknown  out  1  high when the last completed frame matched no glyph.
REQ-010 SHALL have ports: frame_strobe  out  1  one-cycle pulse per completed frame.
REQ-011 SHALL have ports: seq_err  out  1  one-cycle pulse on row-sequence violation.
REQ-012 SHALL have ports: frame_count  out  8  number of completed frames, modulo 256.

Function
REQ-013 SHALL register dot_row/dot_col in an input stage at every edge; all decoding acts on the registered copy (1-cycle sample latency).
REQ-014 SHALL classify the sampled row as: idle (8'h00 or 8'hFF), valid (exactly one bit low, index = 7 minus position of the low bit), or illegal (anything else).
REQ-015 SHALL implement states HUNT and CAPTURE; reset state HUNT.
REQ-016 In HUNT: valid row 0 -> store dot_col into working row 0, go CAPTURE with expected row 1; any other input -> stay HUNT, no error.
REQ-017 In CAPTURE: valid row equal to last accepted row -> overwrite that row (hold tolerated), stay CAPTURE.
REQ-018 In CAPTURE: valid row equal to last accepted +1 -> store row, advance; if that row is 7, complete frame and go HUNT.
REQ-019 In CAPTURE: idle -> ignored, state held; illegal or any other valid row -> seq_err pulse next cycle, discard working frame, go HUNT; if that row is row 0 it SHALL immediately start a new capture (as REQ-016).
REQ-020 On frame completion SHALL copy all 8 working rows (including row 7 being stored) into the shadow frame in the same edge.
REQ-021 One edge after shadow update SHALL register: frame_strobe=1 for exactly one cycle, frame_count+1 (255 wraps to 0), and glyph/glyph_valid/unknown from comparing the shadow frame, rows 0..7, against:
REQ-022 glyph 0: 0C 0C 19 7E 98 18 28 48 (hex).
REQ-023 glyph 1: 00 24 3C BD FF 3C 3C 00.
REQ-024 glyph 2: 18 18 3C 3C 5A 18 18 24.
REQ-025 glyph 3: 18 24 42 81 42 42 42 7E.
REQ-026 Exact match -> glyph=code, glyph_valid=1, unknown=0; no match -> glyph unchanged, glyph_valid=0, unknown=1; these hold until next frame completion.
REQ-027 End-to-end: row 7 presented before edge E -> frame_strobe high in cycle after edge E+2.
REQ-028 rd_col SHALL equal shadow[rd_row] one edge after rd_row is sampled; if shadow updates on the same edge, rd_col returns the pre-update value.
REQ-029 seq_err and frame_strobe SHALL never assert in the same cycle.

Reset
REQ-030 Reset SHALL force: state HUNT, input stage 8'hFF/8'h00, working and shadow frames all 0, rd_col=0, glyph=0, glyph_valid=0, unknown=0, frame_strobe=0, seq_err=0, frame_count=0.
REQ-031 Reset asserted mid-frame SHALL discard partial capture; no frame_strobe or seq_err results from the aborted frame.

Verification
REQ-032 Scan glyph 1 rows 0..7 one per cycle, repeated 3 frames -> frame_strobe pulses 3 times 8 cycles apart, glyph=1, glyph_valid=1, frame_count=3.
REQ-033 Scan glyph 3 with row 4 = 8'h43 -> unknown=1, glyph_valid=0, glyph keeps previous value; rd_row=4 -> rd_col=8'h43.
REQ-034 Rows 0,1,2,4 -> seq_err pulse once, no frame_strobe; following clean scan of glyph 2 -> glyph=2, glyph_valid=1.
REQ-035 Each row held 3 cycles, 8'h00 idle cycles interleaved -> single frame_strobe, glyph decoded correctly, no seq_err.
REQ-036 dot_row=8'b00111111 mid-frame -> seq_err; 256 clean frames -> frame_count wraps to 0.
REQ-037 Reset asserted at row 5 of glyph 0 then released, clean glyph 0 scan -> exactly one frame_strobe, frame_count=1, glyph=0, glyph_valid=1.
